// File: rtl/wb_fetch_ctrl.sv
// Weight-buffer read sequencer: streams len words from base, rpt passes, through a
// credit-gated FWFT FIFO so that PE backpressure never drops a word already in flight.
module wb_fetch_ctrl #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 256,
  parameter int RPT_W      = 8,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [ADDR_W:0]   i_len,
  input  logic [RPT_W-1:0]  i_rpt,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_ovf,
  output logic [ADDR_W-1:0] o_wb_raddr,
  output logic              o_wb_rd_en,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_wdata_vld,
  output logic [DATA_W-1:0] o_w_data,
  output logic              o_w_vld,
  output logic              o_w_last,
  input  logic              i_w_rdy,
  output logic [1:0]        o_state
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_e;

  state_e            state_q;
  logic              busy_q, done_q, ovf_q;
  logic [ADDR_W-1:0] base_q, addr_q;
  logic [ADDR_W:0]   len_q, widx_q;
  logic [RPT_W-1:0]  rpt_q, pass_q;
  logic [CNT_W-1:0]  inflight_q, inflight_d, count_q, count_d;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [RD_LAT-1:0] last_sr_q;
  logic [DATA_W-1:0] mem_data_q [FIFO_DEPTH];
  logic              mem_last_q [FIFO_DEPTH];

  logic issue, end_of_pass, last_issue, vld_acc, pop, push, full, empty;

  // Valid/ready: a word moves to the PE array in every cycle where o_w_vld & i_w_rdy;
  // o_w_data/o_w_last are stable while o_w_vld is high and not yet accepted.
  always_comb begin
    full        = (count_q == CNT_W'(FIFO_DEPTH));
    empty       = (count_q == '0);
    // Credit: every outstanding read already owns a FIFO slot.
    issue       = (state_q == S_FETCH) &&
                  (({1'b0, count_q} + {1'b0, inflight_q}) < (CNT_W+1)'(FIFO_DEPTH));
    end_of_pass = (widx_q == len_q - (ADDR_W+1)'(1));
    last_issue  = issue && end_of_pass && (pass_q == rpt_q - RPT_W'(1));
    vld_acc     = i_wdata_vld && (inflight_q != '0);
    pop         = !empty && i_w_rdy;
    push        = vld_acc && (!full || pop);
    inflight_d  = inflight_q + CNT_W'(issue) - CNT_W'(vld_acc);
    count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  assign o_wb_rd_en = issue;
  assign o_wb_raddr = addr_q;
  assign o_w_vld    = !empty;
  assign o_w_data   = empty ? '0 : mem_data_q[rd_ptr_q];
  assign o_w_last   = !empty && mem_last_q[rd_ptr_q];
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_ovf      = ovf_q;
  assign o_state    = state_q;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data_q[wr_ptr_q] <= i_wdata;
      mem_last_q[wr_ptr_q] <= last_sr_q[RD_LAT-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      base_q     <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      widx_q     <= '0;
      rpt_q      <= '0;
      pass_q     <= '0;
      inflight_q <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      last_sr_q  <= '0;
    end else begin
      inflight_q <= inflight_d;
      count_q    <= count_d;
      if (push) wr_ptr_q <= (wr_ptr_q == PTR_W'(FIFO_DEPTH-1)) ? '0 : wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= (rd_ptr_q == PTR_W'(FIFO_DEPTH-1)) ? '0 : rd_ptr_q + PTR_W'(1);
      if (vld_acc && full && !pop) ovf_q <= 1'b1;
      // Pass-end flag travels alongside the read so it lands with its data word.
      last_sr_q[0] <= issue && end_of_pass;
      for (int i = 1; i < RD_LAT; i++) last_sr_q[i] <= last_sr_q[i-1];
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (i_start) begin
          base_q <= i_base_addr;
          addr_q <= i_base_addr;
          len_q  <= i_len;
          rpt_q  <= (i_rpt == '0) ? RPT_W'(1) : i_rpt;
          widx_q <= '0;
          pass_q <= '0;
          ovf_q  <= 1'b0;
          if (i_len == '0) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= S_FETCH;
            busy_q  <= 1'b1;
          end
        end
        S_FETCH: if (issue) begin
          if (end_of_pass) begin
            widx_q <= '0;
            addr_q <= base_q;
            pass_q <= pass_q + RPT_W'(1);
            if (last_issue) state_q <= S_DRAIN;
          end else begin
            widx_q <= widx_q + (ADDR_W+1)'(1);
            addr_q <= addr_q + ADDR_W'(1);
          end
        end
        S_DRAIN: if (inflight_d == '0 && count_d == '0) begin
          state_q <= S_DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/wb_fetch_ctrl.md
Name: wb_fetch_ctrl

Overview:
Read-side sequencer for the weight buffer (Wb_Buffer internal read port).
- On a start command, streams a block of i_len consecutive 256-bit weight words, starting at i_base_addr, replayed i_rpt times.
- Drives the buffer's read address and read enable, and captures the returned data in a small FWFT FIFO.
- Presents the data to the PE array through a valid/ready handshake, so downstream backpressure never loses data already in flight from the BRAM.

Parameters:
ADDR_W, 12, weight buffer word address width
DATA_W, 256, weight word width
RPT_W, 8, pass-count width
RD_LAT, 1, fixed cycles from o_wb_rd_en to i_wdata_vld
FIFO_DEPTH, 4, output FIFO entries; must be >= RD_LAT+2

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
i_start  in  1  one-cycle start pulse; honoured only when o_busy=0
i_base_addr  in  ADDR_W  first word address, sampled on accepted start
i_len  in  ADDR_W+1  words per pass, sampled on start; 0 = empty job
i_rpt  in  RPT_W  number of passes, sampled on start; 0 treated as 1
o_busy  out  1  high from the cycle after an accepted start until o_done
o_done  out  1  one-cycle pulse at job end
o_ovf  out  1  sticky: returned word arrived while FIFO full; cleared on accepted start
o_wb_raddr  out  ADDR_W  weight buffer read address
o_wb_rd_en  out  1  weight buffer read enable
i_wdata  in  DATA_W  weight buffer read data
i_wdata_vld  in  1  weight buffer read data valid
o_w_data  out  DATA_W  weight word to PE array
o_w_vld  out  1  o_w_data valid
o_w_last  out  1  qualifies o_w_vld: last word of a pass
i_w_rdy  in  1  PE array accepts word when o_w_vld & i_w_rdy

Behaviour:
Reset values:
- All outputs 0, FSM in IDLE.
- Address, pass and word counters 0; FIFO emptied; in-flight counter 0.
- Reset mid-job aborts immediately with no o_done. Any i_wdata_vld arriving after reset is ignored, because the in-flight count is 0.

FSM states: IDLE, FETCH, DRAIN, DONE.
- IDLE -> FETCH on i_start with i_len!=0.
- IDLE -> DONE on i_start with i_len==0. No reads are issued; o_done pulses the cycle after start.
- FETCH -> DRAIN in the cycle the final read (last word, last pass) is issued.
- DRAIN -> DONE when in-flight==0, FIFO empty, and no pop or push is pending.
- DONE -> IDLE unconditionally. o_done=1 only in DONE.
- o_busy=1 in FETCH and DRAIN. i_start while busy is ignored and has no effect on any state.

Read issue rules:
- In FETCH, o_wb_rd_en=1 iff fifo_count + inflight < FIFO_DEPTH. This credit rule guarantees a FIFO slot for every returning word.
- First read is issued the cycle after start, with o_wb_raddr=i_base_addr.
- Each issue increments the word index. At index len-1 the address wraps to base and the pass count increments.
- Addresses wrap modulo 2^ADDR_W: base=0xFFF, len=2 reads 0xFFF then 0x000.
- o_wb_raddr holds its value when o_wb_rd_en=0.

In-flight counter:
- +1 on issue, -1 on i_wdata_vld, with both allowed in the same cycle.
- i_wdata_vld when inflight==0 is dropped and does not set o_ovf.
- The last flag of each read is carried in a RD_LAT-deep shift register aligned with the returning data.

FIFO:
- FWFT; o_w_vld = !empty.
- A word pushed at edge k is visible at edge k+1. Read-to-output latency is therefore RD_LAT+1 cycles.
- Simultaneous push and pop is allowed when full.
- Push while full and no pop: the word is dropped and o_ovf is set. This is unreachable when parameters are legal.

Throughput: with i_w_rdy held high, one word per cycle in steady state.

Test Plan:
- Reset, then start base=0x010, len=4, rpt=1, rdy=1 -> rd_en cycles 1-4 with addr 0x010..0x013; o_w_vld cycles 3-6 with data matching; o_w_last on the 4th word; o_done one cycle after the last pop.
- base=0x020, len=3, rpt=2 -> 6 words in address order 0x20,21,22,20,21,22; o_w_last on words 3 and 6; one o_done.
- len=5, i_w_rdy=0 for 10 cycles then 1 -> rd_en stops after 4 issues (FIFO full); no o_ovf; all 5 words delivered in order; done after the 5th pop.
- Start with len=0 -> no rd_en; o_done on cycle 1; o_busy stays 0. Start with rpt=0, len=2 -> exactly 2 words.
- Second i_start during a busy len=8 job with a different base -> ignored; 8 words from the original base only.
- rst asserted mid-job after 3 words popped -> all outputs 0 next cycle; no o_done; late i_wdata_vld ignored; a new start runs normally.
